// File: rtl/vga_pkg.sv
// Shared timing constants and colour type for the 640x480@60 Hz initials display.
package vga_pkg;

   localparam logic [9:0] HPIXELS = 10'd800;
   localparam logic [9:0] VLINES  = 10'd521;
   localparam logic [9:0] HSYNC_W = 10'd128;
   localparam logic [9:0] VSYNC_W = 10'd2;
   localparam logic [9:0] HBP     = 10'd144;
   localparam logic [9:0] HFP     = 10'd784;
   localparam logic [9:0] VBP     = 10'd31;
   localparam logic [9:0] VFP     = 10'd511;
   localparam logic [9:0] X0      = 10'd288;
   localparam logic [9:0] Y0      = 10'd232;

   typedef struct packed {
      logic [2:0] red;
      logic [2:0] green;
      logic [1:0] blue;
   } rgb332_t;

   localparam rgb332_t RGB_BLACK = '{red: 3'd0, green: 3'd0, blue: 2'd0};
   localparam rgb332_t RGB_WHITE = '{red: 3'd7, green: 3'd7, blue: 2'd3};
   localparam rgb332_t RGB_BLUE  = '{red: 3'd0, green: 3'd0, blue: 2'd3};

endpackage

// File: rtl/vga_if.sv
// Board-pin side of the VGA display: syncs plus 3:3:2 colour.
interface vga_if;
   logic       hsync;
   logic       vsync;
   logic [2:0] red;
   logic [2:0] green;
   logic [1:0] blue;

   modport master (output hsync, vsync, red, green, blue);
   modport slave  (input  hsync, vsync, red, green, blue);
endinterface

// File: rtl/vga_640x480.sv
// Pixel-rate enable, horizontal/vertical counters and registered syncs for 640x480.
module vga_640x480
   import vga_pkg::*;
#(
   parameter logic [9:0] P_VLINES = VLINES,
   parameter logic [9:0] P_VBP    = VBP,
   parameter logic [9:0] P_VFP    = VFP
) (
   input  logic       i_clk,
   input  logic       i_rst,
   output logic       o_pix_en,
   output logic [9:0] o_hc,
   output logic [9:0] o_vc,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_visible
);

   logic       r_pix_en;
   logic [9:0] r_hc;
   logic [9:0] r_vc;
   logic       r_hsync;
   logic       r_vsync;
   logic       w_line_end;
   logic       w_frame_end;

   assign w_line_end  = (r_hc == HPIXELS - 10'd1);
   assign w_frame_end = (r_vc == P_VLINES - 10'd1);

   // Syncs are registered from the counter values of the pixel being left,
   // so they carry the same one-pixel latency as the colour outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pix_en <= 1'b0;
         r_hc     <= '0;
         r_vc     <= '0;
         r_hsync  <= 1'b1;
         r_vsync  <= 1'b1;
      end else begin
         r_pix_en <= ~r_pix_en;
         if (r_pix_en) begin
            r_hsync <= (r_hc >= HSYNC_W);
            r_vsync <= (r_vc >= VSYNC_W);
            if (w_line_end) begin
               r_hc <= '0;
               if (w_frame_end) r_vc <= '0;
               else             r_vc <= r_vc + 10'd1;
            end else begin
               r_hc <= r_hc + 10'd1;
            end
         end
      end
   end

   assign o_pix_en  = r_pix_en;
   assign o_hc      = r_hc;
   assign o_vc      = r_vc;
   assign o_hsync   = r_hsync;
   assign o_vsync   = r_vsync;
   assign o_visible = (r_hc >= HBP) && (r_hc < HFP) && (r_vc >= P_VBP) && (r_vc < P_VFP);

endmodule

// File: rtl/vga_initials_top.sv
// VGA top: sync generation plus a 32x16 initials bitmap drawn 2x-scaled on a blue field.
module vga_initials_top
   import vga_pkg::*;
#(
   parameter logic [9:0] P_VLINES = VLINES,
   parameter logic [9:0] P_VBP    = VBP,
   parameter logic [9:0] P_VFP    = VFP,
   parameter logic [9:0] P_Y0     = Y0
) (
   input  logic mclk,
   input  logic btn,
   vga_if.master o_vga
);

   logic        w_pix_en;
   logic        w_hsync;
   logic        w_vsync;
   logic        w_visible;
   logic [9:0]  w_hc;
   logic [9:0]  w_vc;
   logic [9:0]  w_x;
   logic [9:0]  w_y;
   logic        w_in_box;
   logic [3:0]  w_row;
   logic [4:0]  w_col;
   logic [31:0] w_rom_word;
   logic        w_bit;
   rgb332_t     w_rgb_next;
   rgb332_t     r_rgb;

   vga_640x480 #(
      .P_VLINES (P_VLINES),
      .P_VBP    (P_VBP),
      .P_VFP    (P_VFP)
   ) u_timing (
      .i_clk     (mclk),
      .i_rst     (btn),
      .o_pix_en  (w_pix_en),
      .o_hc      (w_hc),
      .o_vc      (w_vc),
      .o_hsync   (w_hsync),
      .o_vsync   (w_vsync),
      .o_visible (w_visible)
   );

   assign w_x      = w_hc - HBP;
   assign w_y      = w_vc - P_VBP;
   assign w_in_box = (w_x >= X0) && (w_x < X0 + 10'd64) &&
                     (w_y >= P_Y0) && (w_y < P_Y0 + 10'd32);
   assign w_col    = 5'((w_x - X0) >> 1);
   assign w_row    = 4'((w_y - P_Y0) >> 1);

   // Rows 0 and 15 form the top/bottom border; the sides frame the letters.
   always_comb begin
      w_rom_word = 32'h0000_0000;
      case (w_row)
         4'd0:  w_rom_word = 32'hFFFF_FFFF;
         4'd1:  w_rom_word = 32'h8000_0001;
         4'd2:  w_rom_word = 32'h81FC_3061;
         4'd3:  w_rom_word = 32'h8030_30C1;
         4'd4:  w_rom_word = 32'h8030_3181;
         4'd5:  w_rom_word = 32'h8030_3301;
         4'd6:  w_rom_word = 32'h8030_3601;
         4'd7:  w_rom_word = 32'h8030_3C01;
         4'd8:  w_rom_word = 32'h8030_3C01;
         4'd9:  w_rom_word = 32'h8030_3601;
         4'd10: w_rom_word = 32'h8630_3301;
         4'd11: w_rom_word = 32'h8630_3181;
         4'd12: w_rom_word = 32'h8660_30C1;
         4'd13: w_rom_word = 32'h83C0_3061;
         4'd14: w_rom_word = 32'h8000_0001;
         4'd15: w_rom_word = 32'hFFFF_FFFF;
         default: w_rom_word = 32'h0000_0000;
      endcase
   end

   assign w_bit = w_rom_word[5'd31 - w_col];

   always_comb begin
      w_rgb_next = RGB_BLACK;
      if (w_visible) w_rgb_next = (w_in_box && w_bit) ? RGB_WHITE : RGB_BLUE;
   end

   always_ff @(posedge mclk or posedge btn) begin
      if (btn)           r_rgb <= RGB_BLACK;
      else if (w_pix_en) r_rgb <= w_rgb_next;
   end

   assign o_vga.hsync = w_hsync;
   assign o_vga.vsync = w_vsync;
   assign o_vga.red   = r_rgb.red;
   assign o_vga.green = r_rgb.green;
   assign o_vga.blue  = r_rgb.blue;

endmodule

// File: tb/tb_vga_initials_top.sv
// Directed bench: full-size instance for sync timing and reset, short-frame instance for pixels and frame wrap.
`timescale 1ns/1ps
module tb_vga_initials_top;

   logic mclk;
   logic btn;
   int   n_checks;
   int   n_fail;

   vga_if vga_m ();
   vga_if vga_s ();

   vga_initials_top dut_m (
      .mclk  (mclk),
      .btn   (btn),
      .o_vga (vga_m)
   );

   // Short frame (37 lines, box at y=1) so the bitmap and frame wrap are reached quickly.
   vga_initials_top #(
      .P_VLINES (10'd37),
      .P_VBP    (10'd3),
      .P_VFP    (10'd36),
      .P_Y0     (10'd1)
   ) dut_s (
      .mclk  (mclk),
      .btn   (btn),
      .o_vga (vga_s)
   );

   initial mclk = 1'b0;
   always #10 mclk = ~mclk;

   localparam int NPIX = 14;
   // pixel index p = vc*800 + hc; expected {red,green,blue}
   int         pix_p [NPIX] = '{2032, 2832, 3632, 5232, 5234, 8010, 8143, 8144,
                                8200, 28495, 28496, 28783, 28784, 29232};
   logic [7:0] pix_e [NPIX] = '{8'h00, 8'h03, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h03,
                                8'h03, 8'hFF, 8'h03, 8'h03, 8'h00, 8'h00};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rgb_m();
      return {vga_m.red, vga_m.green, vga_m.blue};
   endfunction

   function automatic logic [7:0] rgb_s();
      return {vga_s.red, vga_s.green, vga_s.blue};
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      btn      = 1'b1;
      #50;
      chk("rst_hsync", 32'(vga_m.hsync), 32'd1);
      chk("rst_vsync", 32'(vga_m.vsync), 32'd1);
      chk("rst_rgb",   32'(rgb_m()),     32'd0);
      chk("rst_rgb_s", 32'(rgb_s()),     32'd0);
      #50;
      btn = 1'b0;
      #1;
      chk("rel_hc", 32'(dut_m.u_timing.r_hc), 32'd0);
      chk("rel_vc", 32'(dut_m.u_timing.r_vc), 32'd0);

      fork
         begin : thr_sync
            int n;
            int hs_fall1, hs_rise, hs_fall2, vs_fall1, vs_rise;
            hs_fall1 = 0; hs_rise = 0; hs_fall2 = 0; vs_fall1 = 0; vs_rise = 0;
            for (n = 1; n <= 3300; n++) begin
               @(posedge mclk); #1;
               if (n == 1) chk("hsync_edge1", 32'(vga_m.hsync), 32'd1);
               if (hs_fall1 == 0 && !vga_m.hsync) hs_fall1 = n;
               else if (hs_fall1 != 0 && hs_rise == 0 && vga_m.hsync) hs_rise = n;
               else if (hs_rise != 0 && hs_fall2 == 0 && !vga_m.hsync) hs_fall2 = n;
               if (vs_fall1 == 0 && !vga_m.vsync) vs_fall1 = n;
               else if (vs_fall1 != 0 && vs_rise == 0 && vga_m.vsync) vs_rise = n;
            end
            chk("hsync_first_low", 32'(hs_fall1), 32'd2);
            chk("hsync_low_mclk", 32'(hs_rise - hs_fall1), 32'd256);
            chk("hsync_period_mclk", 32'(hs_fall2 - hs_fall1), 32'd1600);
            chk("vsync_first_low", 32'(vs_fall1), 32'd2);
            chk("vsync_low_mclk", 32'(vs_rise - vs_fall1), 32'd3200);
         end
         begin : thr_pix
            int n;
            int k;
            k = 0;
            for (n = 1; n <= 59200; n++) begin
               @(posedge mclk); #1;
               if (k < NPIX && n == 2 * pix_p[k] + 2) begin
                  chk($sformatf("pix_%0d", pix_p[k]), 32'(rgb_s()), 32'(pix_e[k]));
                  k++;
               end
               if (n == 59198) begin
                  chk("pre_wrap_hc", 32'(dut_s.u_timing.r_hc), 32'd799);
                  chk("pre_wrap_vc", 32'(dut_s.u_timing.r_vc), 32'd36);
               end
               if (n == 59200) begin
                  chk("wrap_hc", 32'(dut_s.u_timing.r_hc), 32'd0);
                  chk("wrap_vc", 32'(dut_s.u_timing.r_vc), 32'd0);
               end
            end
            chk("pix_sched_done", 32'(k), 32'(NPIX));
         end
      join

      @(negedge mclk);
      btn = 1'b1;
      #100;
      btn = 1'b0;
      repeat (800) @(posedge mclk);
      #5;
      chk("mid_hc_pre", 32'(dut_m.u_timing.r_hc), 32'd400);
      chk("mid_vsync_pre", 32'(vga_m.vsync), 32'd0);
      btn = 1'b1;
      #1;
      chk("mid_hsync", 32'(vga_m.hsync), 32'd1);
      chk("mid_vsync", 32'(vga_m.vsync), 32'd1);
      chk("mid_rgb", 32'(rgb_m()), 32'd0);
      chk("mid_hc", 32'(dut_m.u_timing.r_hc), 32'd0);
      chk("mid_vc", 32'(dut_m.u_timing.r_vc), 32'd0);
      chk("mid_pix_en", 32'(dut_m.u_timing.r_pix_en), 32'd0);
      #38;
      chk("mid_hc_held", 32'(dut_m.u_timing.r_hc), 32'd0);
      #1;
      btn = 1'b0;

      for (int e = 1; e <= 8; e++) begin
         @(posedge mclk); #1;
         chk($sformatf("cad_pix_en_%0d", e), 32'(dut_m.u_timing.r_pix_en), 32'(e % 2));
         chk($sformatf("cad_hc_%0d", e), 32'(dut_m.u_timing.r_hc), 32'(e / 2));
         chk($sformatf("cad_vc_%0d", e), 32'(dut_m.u_timing.r_vc), 32'd0);
         if (e == 2) chk("cad_hsync_low", 32'(vga_m.hsync), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
